// File: rtl/alu.sv
// alu: combinational 32-bit RV32I integer ALU with a registered copy of the
// result and zero flag.
//
// Ports:
//   clk            clock, used only by the registered outputs
//   rst            synchronous active-high reset for the registered outputs
//   operation[3:0] ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9,
//                  codes 10-15 reserved (result 0)
//   data1[31:0]    operand A (rs1)
//   data2[31:0]    operand B (rs2 or immediate)
//   outputData     combinational result
//   zero           combinational, high when outputData == 0
//   outputDataReg  outputData registered on clk
//   zeroReg        zero registered on clk
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  operation,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] outputData,
  output logic        zero,
  output logic [31:0] outputDataReg,
  output logic        zeroReg
);

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpXor  = 4'd2,
    OpOr   = 4'd3,
    OpAnd  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9
  } alu_op_e;

  logic [4:0]  shamt;
  logic [31:0] sra_result;
  logic        slt_bit;
  logic        sltu_bit;
  logic [31:0] result;

  // Only the low five bits of operand B select the shift amount.
  assign shamt      = data2[4:0];
  assign sra_result = $unsigned($signed(data1) >>> shamt);
  assign slt_bit    = $signed(data1) < $signed(data2);
  assign sltu_bit   = data1 < data2;

  always_comb begin
    result = 32'd0;
    case (alu_op_e'(operation))
      OpAdd:   result = data1 + data2;
      OpSub:   result = data1 - data2;
      OpXor:   result = data1 ^ data2;
      OpOr:    result = data1 | data2;
      OpAnd:   result = data1 & data2;
      OpSll:   result = data1 << shamt;
      OpSrl:   result = data1 >> shamt;
      OpSra:   result = sra_result;
      OpSlt:   result = {31'd0, slt_bit};
      OpSltu:  result = {31'd0, sltu_bit};
      default: result = 32'd0;  // reserved codes
    endcase
  end

  assign outputData = result;
  assign zero       = (result == 32'd0);

  // Reset clears both registered outputs, including zeroReg, so a reset
  // value is distinguishable from a captured zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      outputDataReg <= 32'd0;
      zeroReg       <= 1'b0;
    end else begin
      outputDataReg <= outputData;
      zeroReg       <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu, covering every operation, shift
// amount masking, signed/unsigned compare boundaries, reserved codes and the
// registered path including reset priority.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  operation;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] outputData;
  logic        zero;
  logic [31:0] outputDataReg;
  logic        zeroReg;

  int vectors;
  int miscompares;

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .operation     (operation),
    .data1         (data1),
    .data2         (data2),
    .outputData    (outputData),
    .zero          (zero),
    .outputDataReg (outputDataReg),
    .zeroReg       (zeroReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands, let the combinational path settle, check result and flag.
  task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
    operation = op;
    data1     = a;
    data2     = b;
    #1;
    check(tag, outputData, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  // Drive inputs after a falling edge; sample registered outputs just past
  // the next rising edge.
  task automatic step(input logic r, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    rst       = r;
    operation = op;
    data1     = a;
    data2     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    operation   = 4'd0;
    data1       = 32'd0;
    data2       = 32'd0;

    // Registered path under reset: zero is 1 combinationally, zeroReg stays 0.
    step(1'b1, 4'd0, 32'd0, 32'd0);
    step(1'b1, 4'd0, 32'd0, 32'd0);
    check("rst_data", outputDataReg, 32'd0);
    check("rst_zero", {31'd0, zeroReg}, 32'd0);
    check("rst_comb_zero", {31'd0, zero}, 32'd1);

    // Reset does not touch the combinational path.
    operation = 4'd0; data1 = 32'd10; data2 = 32'd5;
    #1;
    check("comb_during_rst", outputData, 32'd15);

    comb("add",       4'd0, 32'd10,         32'd5,          32'd15,         1'b0);
    comb("sub_neg",   4'd1, 32'd10,         32'd15,         32'hFFFF_FFFB,  1'b0);
    comb("add_wrap",  4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
    comb("sub_eq",    4'd1, 32'h1234_5678,  32'h1234_5678,  32'd0,          1'b1);
    comb("xor",       4'd2, 32'hAAAA_5555,  32'h0F0F_F0F0,  32'hA5A5_A5A5,  1'b0);
    comb("or",        4'd3, 32'hF0F0_F0F0,  32'h0FF0_00FF,  32'hFFF0_F0FF,  1'b0);
    comb("and",       4'd4, 32'hF0F0_F0F0,  32'h0FF0_00FF,  32'h00F0_00F0,  1'b0);
    comb("sll",       4'd5, 32'd1,          32'd3,          32'd8,          1'b0);
    comb("srl",       4'd6, 32'h8000_0000,  32'd1,          32'h4000_0000,  1'b0);
    comb("sra",       4'd7, 32'h8000_0000,  32'd1,          32'hC000_0000,  1'b0);
    comb("sra_ones",  4'd7, 32'hFFFF_FFFF,  32'd4,          32'hFFFF_FFFF,  1'b0);
    comb("sra_pos",   4'd7, 32'h7000_0000,  32'd4,          32'h0700_0000,  1'b0);
    comb("sll_mask",  4'd5, 32'd1,          32'h21,         32'd2,          1'b0);
    comb("srl_mask",  4'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          1'b0);
    comb("sll_31",    4'd5, 32'd3,          32'd31,         32'h8000_0000,  1'b0);
    comb("slt_neg",   4'd8, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
    comb("slt_pos",   4'd8, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1);
    comb("sltu_big",  4'd9, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
    comb("sltu_sml",  4'd9, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0);
    comb("slt_eq",    4'd8, 32'd7,          32'd7,          32'd0,          1'b1);
    comb("res_12",    4'd12, 32'hDEAD_BEEF, 32'h1234_5678,  32'd0,          1'b1);
    comb("res_10",    4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0,          1'b1);
    comb("res_15",    4'd15, 32'd10,        32'd5,          32'd0,          1'b1);

    // Capture resumes on the first edge with rst low.
    step(1'b0, 4'd0, 32'd10, 32'd5);
    check("reg_add", outputDataReg, 32'd15);
    check("reg_add_zero", {31'd0, zeroReg}, 32'd0);

    step(1'b0, 4'd12, 32'd3, 32'd4);
    check("reg_res", outputDataReg, 32'd0);
    check("reg_res_zero", {31'd0, zeroReg}, 32'd1);

    step(1'b0, 4'd1, 32'd10, 32'd15);
    check("reg_sub", outputDataReg, 32'hFFFF_FFFB);

    // Reset mid-stream wins over a nonzero capture.
    step(1'b1, 4'd0, 32'd10, 32'd5);
    check("reg_mid_rst", outputDataReg, 32'd0);
    check("reg_mid_rst_zero", {31'd0, zeroReg}, 32'd0);

    step(1'b0, 4'd0, 32'd10, 32'd5);
    check("reg_resume", outputDataReg, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
